// File: rtl/spi_lcd_streamer_if.sv
`default_nettype none
// =============================================================================
// spi_lcd_streamer_if : valid/ready word stream into the SPI LCD streamer
// Revision: 1.0
// =============================================================================
interface spi_lcd_streamer_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  IN_VALID;
   logic                  IN_READY;
   logic [DATA_WIDTH-1:0] IN_DATA;
   logic                  IN_DC;
   logic                  IN_DELAY;
   logic                  IN_LAST;

   modport master (
      output IN_VALID, IN_DATA, IN_DC, IN_DELAY, IN_LAST,
      input  IN_READY
   );

   modport slave (
      input  IN_VALID, IN_DATA, IN_DC, IN_DELAY, IN_LAST,
      output IN_READY
   );
endinterface
`default_nettype wire

// File: rtl/spi_lcd_streamer.sv
`default_nettype none
// =============================================================================
// spi_lcd_streamer : panel reset/power-up sequencer plus SPI mode-0 word streamer
// Revision: 1.0
// =============================================================================
module spi_lcd_streamer #(
   parameter int CLOCK_SPEED_MHZ = 12,
   parameter int SPI_DIV         = 2,
   parameter int DATA_WIDTH      = 8,
   parameter int RESET_LOW_US    = 10,
   parameter int RESET_WAIT_MS   = 120
) (
   input  logic                SYSTEM_CLK,
   input  logic                SYSTEM_RST,
   spi_lcd_streamer_if.slave   s_in,
   input  logic                HW_RESET_REQ,
   output logic                INIT_DONE,
   output logic                BUSY,
   output logic                CS,
   output logic                MOSI,
   output logic                DC,
   output logic                LCD_CLK,
   output logic                LCD_RESET
);
   localparam int          c_BIT_W       = $clog2(DATA_WIDTH);
   localparam logic [31:0] c_RST_LOW_CYC = 32'(RESET_LOW_US * CLOCK_SPEED_MHZ);
   localparam logic [31:0] c_RST_WAIT_CYC = 32'(RESET_WAIT_MS * 1000 * CLOCK_SPEED_MHZ);
   localparam logic [31:0] c_RST_LOW_M1  = (c_RST_LOW_CYC == 32'd0) ? 32'd0 : c_RST_LOW_CYC - 32'd1;
   localparam logic [31:0] c_RST_WAIT_M1 = (c_RST_WAIT_CYC == 32'd0) ? 32'd0 : c_RST_WAIT_CYC - 32'd1;
   localparam logic [31:0] c_DIV_M1      = 32'(SPI_DIV - 1);
   localparam logic [31:0] c_MS_CYC      = 32'(CLOCK_SPEED_MHZ * 1000);
   localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      RST_LOW  = 3'd0,
      RST_WAIT = 3'd1,
      IDLE     = 3'd2,
      SHIFT    = 3'd3,
      CS_HOLD  = 3'd4,
      DELAY    = 3'd5
   } state_t;

   state_t                r_state;
   logic [31:0]           r_cnt;
   logic [31:0]           r_dly_end;
   logic [c_BIT_W-1:0]    r_bit;
   logic                  r_phase;
   logic [DATA_WIDTH-2:0] r_shreg;
   logic                  r_last;

   logic [15:0]           w_ms;
   logic [31:0]           w_dly_cyc;

   // Delay tokens carry the ms count in the low 16 bits; narrow words zero-extend.
   generate
      if (DATA_WIDTH >= 16) begin : g_ms_wide
         assign w_ms = s_in.IN_DATA[15:0];
      end else begin : g_ms_narrow
         assign w_ms = {{(16-DATA_WIDTH){1'b0}}, s_in.IN_DATA};
      end
   endgenerate

   assign w_dly_cyc      = 32'(w_ms) * c_MS_CYC;
   assign s_in.IN_READY  = (r_state == IDLE) && !HW_RESET_REQ;
   assign BUSY           = (r_state != IDLE);

   always_ff @(posedge SYSTEM_CLK or posedge SYSTEM_RST) begin
      if (SYSTEM_RST) begin
         r_state   <= RST_LOW;
         r_cnt     <= 32'd0;
         r_dly_end <= 32'd0;
         r_bit     <= '0;
         r_phase   <= 1'b0;
         r_shreg   <= '0;
         r_last    <= 1'b0;
         INIT_DONE <= 1'b0;
         CS        <= 1'b1;
         MOSI      <= 1'b0;
         DC        <= 1'b0;
         LCD_CLK   <= 1'b0;
         LCD_RESET <= 1'b0;
      end else begin
         case (r_state)
            RST_LOW: begin
               if (r_cnt >= c_RST_LOW_M1) begin
                  LCD_RESET <= 1'b1;
                  r_cnt     <= 32'd0;
                  r_state   <= RST_WAIT;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            RST_WAIT: begin
               if (r_cnt >= c_RST_WAIT_M1) begin
                  INIT_DONE <= 1'b1;
                  r_cnt     <= 32'd0;
                  r_state   <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            IDLE: begin
               if (HW_RESET_REQ) begin
                  CS        <= 1'b1;
                  INIT_DONE <= 1'b0;
                  LCD_RESET <= 1'b0;
                  r_cnt     <= 32'd0;
                  r_state   <= RST_LOW;
               end else if (s_in.IN_VALID && s_in.IN_DELAY) begin
                  CS        <= 1'b1;
                  r_cnt     <= 32'd0;
                  r_dly_end <= (w_dly_cyc == 32'd0) ? 32'd0 : w_dly_cyc - 32'd1;
                  r_state   <= DELAY;
               end else if (s_in.IN_VALID) begin
                  CS      <= 1'b0;
                  DC      <= s_in.IN_DC;
                  MOSI    <= s_in.IN_DATA[DATA_WIDTH-1];
                  LCD_CLK <= 1'b0;
                  r_shreg <= s_in.IN_DATA[DATA_WIDTH-2:0];
                  r_last  <= s_in.IN_LAST;
                  r_cnt   <= 32'd0;
                  r_bit   <= '0;
                  r_phase <= 1'b0;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               if (r_cnt != c_DIV_M1) begin
                  r_cnt <= r_cnt + 32'd1;
               end else begin
                  r_cnt <= 32'd0;
                  if (!r_phase) begin
                     LCD_CLK <= 1'b1;
                     r_phase <= 1'b1;
                  end else begin
                     LCD_CLK <= 1'b0;
                     r_phase <= 1'b0;
                     if (r_bit == c_LAST_BIT) begin
                        r_state <= r_last ? CS_HOLD : IDLE;
                     end else begin
                        // Next bit launches at the start of its low phase.
                        r_bit   <= r_bit + 1'b1;
                        MOSI    <= r_shreg[DATA_WIDTH-2];
                        r_shreg <= {r_shreg[DATA_WIDTH-3:0], 1'b0};
                     end
                  end
               end
            end
            CS_HOLD: begin
               if (r_cnt >= c_DIV_M1) begin
                  CS      <= 1'b1;
                  r_cnt   <= 32'd0;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            DELAY: begin
               if (r_cnt >= r_dly_end) begin
                  r_cnt   <= 32'd0;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            default: begin
               r_state <= RST_LOW;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_spi_lcd_streamer.sv
`default_nettype none
// =============================================================================
// tb_spi_lcd_streamer : scoreboard bench for the SPI LCD streamer
// Revision: 1.0
// =============================================================================
module tb_spi_lcd_streamer;
   localparam int MHZ      = 1;
   localparam int DIV      = 2;
   localparam int DW       = 8;
   localparam int RLU      = 2;
   localparam int RWM      = 1;
   localparam int WORD_CYC = 2 * DIV * DW;
   localparam int LIMIT    = 20000;

   typedef struct {
      logic [DW-1:0] data;
      logic          dc;
   } word_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic hw_req = 1'b0;
   logic init_done, busy, cs, mosi, dc, lcd_clk, lcd_rst;
   bit   g_abort = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   word_t wq[$];
   int    csq[$];

   spi_lcd_streamer_if #(.DATA_WIDTH(DW)) u_if ();

   spi_lcd_streamer #(
      .CLOCK_SPEED_MHZ(MHZ),
      .SPI_DIV        (DIV),
      .DATA_WIDTH     (DW),
      .RESET_LOW_US   (RLU),
      .RESET_WAIT_MS  (RWM)
   ) u_dut (
      .SYSTEM_CLK  (clk),
      .SYSTEM_RST  (rst),
      .s_in        (u_if),
      .HW_RESET_REQ(hw_req),
      .INIT_DONE   (init_done),
      .BUSY        (busy),
      .CS          (cs),
      .MOSI        (mosi),
      .DC          (dc),
      .LCD_CLK     (lcd_clk),
      .LCD_RESET   (lcd_rst)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      n_vec++;
      n_err++;
      $display("FAIL %s", nm);
   endtask

   // Word monitor: assemble MSB-first bits on LCD_CLK rising edges.
   logic [DW-1:0] m_sh = '0;
   int            m_nb = 0;
   logic          m_dc = 1'b0;
   logic          m_bad = 1'b0;
   always @(posedge lcd_clk or posedge rst) begin
      if (rst) begin
         m_nb = 0;
      end else begin
         word_t e;
         if (m_nb == 0) begin
            m_dc  = dc;
            m_bad = 1'b0;
         end
         if (dc !== m_dc || cs !== 1'b0) m_bad = 1'b1;
         m_sh = {m_sh[DW-2:0], mosi};
         m_nb++;
         if (m_nb == DW) begin
            m_nb = 0;
            if (wq.size() == 0) begin
               fail_now("spi_word_unexpected");
            end else begin
               e = wq.pop_front();
               chk("spi_word_data", m_sh, e.data);
               chk("spi_word_dc", m_dc, e.dc);
               chk("spi_word_stable", m_bad, 0);
            end
         end
      end
   end

   // CS monitor: length of each chip-select low window in clock cycles.
   initial begin
      forever begin
         int n;
         @(negedge cs);
         n = 0;
         while (cs === 1'b0 && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
         end
         if (!g_abort) begin
            if (csq.size() == 0) fail_now("cs_window_unexpected");
            else chk("cs_low_cycles", n, csq.pop_front());
         end
      end
   end

   task automatic send(input logic [DW-1:0] d, input logic wdc, input logic dly,
                       input logic last, input bit push, output int waited);
      logic rdy;
      u_if.IN_DATA  = d;
      u_if.IN_DC    = wdc;
      u_if.IN_DELAY = dly;
      u_if.IN_LAST  = last;
      u_if.IN_VALID = 1'b1;
      waited = 0;
      do begin
         @(negedge clk);
         rdy = u_if.IN_READY;
         @(posedge clk);
         waited++;
      end while (!rdy && waited < LIMIT);
      #1;
      u_if.IN_VALID = 1'b0;
      if (!rdy) fail_now("accept_timeout");
      else if (push && !dly) wq.push_back('{data: d, dc: wdc});
   endtask

   task automatic check_init(input string tag);
      int n;
      bit bad;
      n = 0;
      bad = 1'b0;
      while (lcd_rst !== 1'b1 && n < LIMIT) begin
         if (u_if.IN_READY !== 1'b0 || cs !== 1'b1) bad = 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_reset_low_cycles"}, n, RLU * MHZ);
      n = 0;
      while (init_done !== 1'b1 && n < LIMIT) begin
         if (u_if.IN_READY !== 1'b0 || cs !== 1'b1) bad = 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_wait_cycles"}, n, RWM * 1000 * MHZ);
      chk({tag, "_quiet_during_init"}, bad, 0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy !== 1'b0 || cs !== 1'b1) && n < LIMIT) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= LIMIT) fail_now("idle_timeout");
   endtask

   task automatic do_delay(input int ms);
      int w, n, exp_n;
      bit bad;
      send(DW'(ms), 1'b0, 1'b1, 1'b0, 1'b1, w);
      n = 0;
      bad = 1'b0;
      while (busy === 1'b1 && n < LIMIT) begin
         if (lcd_clk !== 1'b0 || cs !== 1'b1) bad = 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
      exp_n = ms * 1000 * MHZ;
      if (exp_n == 0) exp_n = 1;
      chk("delay_busy_cycles", n, exp_n);
      chk("delay_bus_quiet", bad, 0);
   endtask

   function automatic int cs_window(input int k);
      return k * (WORD_CYC + 1) + DIV - 1;
   endfunction

   initial begin
      #3_000_000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, r, n, k;
      logic prev;
      u_if.IN_VALID = 1'b0;
      u_if.IN_DATA  = '0;
      u_if.IN_DC    = 1'b0;
      u_if.IN_DELAY = 1'b0;
      u_if.IN_LAST  = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_values", {lcd_rst, cs, mosi, dc, lcd_clk, u_if.IN_READY, init_done, busy},
          8'b0100_0001);
      rst = 1'b0;
      check_init("por");

      csq.push_back(cs_window(1));
      send(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, w);
      chk("first_accept_latency", w, 1);
      wait_idle();
      chk("ready_after_word", u_if.IN_READY, 1);

      csq.push_back(cs_window(2));
      send(8'h2A, 1'b0, 1'b0, 1'b0, 1'b1, w);
      send(8'h00, 1'b1, 1'b0, 1'b1, 1'b1, w);
      chk("b2b_accept_gap", w, WORD_CYC + 1);
      wait_idle();

      do_delay(3);
      csq.push_back(cs_window(1));
      send(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, w);
      chk("accept_after_delay", w, 1);
      wait_idle();
      do_delay(0);

      @(negedge clk);
      u_if.IN_DATA  = 8'h5A;
      u_if.IN_DC    = 1'b1;
      u_if.IN_DELAY = 1'b0;
      u_if.IN_LAST  = 1'b1;
      u_if.IN_VALID = 1'b1;
      hw_req = 1'b1;
      #1;
      chk("ready_blocked_by_req", u_if.IN_READY, 0);
      @(posedge clk);
      #1;
      hw_req = 1'b0;
      chk("req_entry_state", {init_done, lcd_rst, cs}, 3'b001);
      check_init("hwreq");
      csq.push_back(cs_window(1));
      send(8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, w);
      chk("accept_after_reinit", w, 1);
      wait_idle();

      g_abort = 1'b1;
      send(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, w);
      r = 0;
      n = 0;
      prev = 1'b0;
      while (r < 4 && n < LIMIT) begin
         @(posedge clk);
         #1;
         n++;
         if (lcd_clk && !prev) r++;
         prev = lcd_clk;
      end
      #2;
      rst = 1'b1;
      #1;
      chk("abort_outputs", {cs, lcd_clk, lcd_rst, init_done}, 4'b1000);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_init("abort");
      g_abort = 1'b0;

      for (int t = 0; t < 15; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            do_delay($urandom_range(0, 1));
         end else begin
            k = $urandom_range(1, 3);
            csq.push_back(cs_window(k));
            for (int i = 0; i < k; i++) begin
               send(DW'($urandom), 1'($urandom), 1'b0, (i == k - 1), 1'b1, w);
               if (i == 0) chk("rand_first_latency", w, 1);
               else chk("rand_b2b_gap", w, WORD_CYC + 1);
            end
            wait_idle();
         end
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      repeat (10) @(posedge clk);
      #1;
      chk("sb_words_left", wq.size(), 0);
      chk("sb_cs_windows_left", csq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/spi_lcd_streamer.md
Name: spi_lcd_streamer

Overview:
Parametrised SPI LCD front end for ST7735-class panels. It replaces the free-running delay divider with one sequencer that owns the panel interface.
- Runs the hardware reset pulse and the power-up wait.
- Then streams command/data words from a valid/ready interface onto SPI mode 0 with per-word DC.
- Executes in-stream millisecond delay tokens, so init tables can live upstream in ROM.

Parameters:
CLOCK_SPEED_MHZ, 12, SYSTEM_CLK frequency in MHz (integer >=1).
SPI_DIV, 2, SYSTEM_CLK cycles per LCD_CLK half period (>=1).
DATA_WIDTH, 8, bits per SPI word, MSB first (8..32).
RESET_LOW_US, 10, LCD_RESET low time in us.
RESET_WAIT_MS, 120, wait after LCD_RESET rises before accepting input, in ms.

Ports:
SYSTEM_CLK  in  1  system clock; all logic on its rising edge.
SYSTEM_RST  in  1  asynchronous, active-high reset.
IN_VALID  in  1  word/token offered.
IN_READY  out  1  block accepts on IN_VALID&&IN_READY.
IN_DATA  in  DATA_WIDTH  SPI word; for delay tokens, IN_DATA[15:0] = ms count.
IN_DC  in  1  DC level for this word (0 command, 1 data).
IN_DELAY  in  1  1 = delay token: no SPI traffic.
IN_LAST  in  1  1 = deassert CS after this word.
HW_RESET_REQ  in  1  request to re-run the panel reset sequence.
INIT_DONE  out  1  high once the reset/wait sequence completes.
BUSY  out  1  high in any state other than IDLE.
CS  out  1  chip select, active low.
MOSI  out  1  serial data.
DC  out  1  data/command select.
LCD_CLK  out  1  SPI clock; idles low.
LCD_RESET  out  1  panel reset, active low.

Behaviour:
- Async reset values:
  - state RST_LOW, LCD_RESET=0, CS=1, MOSI=0, DC=0, LCD_CLK=0.
  - IN_READY=0, INIT_DONE=0, BUSY=1.
- State RST_LOW:
  - Lasts RESET_LOW_US*CLOCK_SPEED_MHZ cycles after reset release.
  - Then LCD_RESET=1 and the state moves to RST_WAIT.
- State RST_WAIT:
  - Lasts RESET_WAIT_MS*1000*CLOCK_SPEED_MHZ cycles.
  - Then INIT_DONE=1 and the state moves to IDLE. INIT_DONE stays high until reset or HW_RESET_REQ.
- State IDLE:
  - IN_READY=1 combinationally only in IDLE; IN_READY is 0 in every other state.
  - CS holds its previous level, so a multi-word transaction keeps CS low between words.
- Priority in IDLE, same cycle:
  1. HW_RESET_REQ: go to RST_LOW, CS=1, INIT_DONE=0, the offered word is NOT accepted (IN_READY forced 0 that cycle).
  2. Accepted delay token.
  3. Accepted SPI word.
  HW_RESET_REQ is ignored outside IDLE.
- Accepted SPI word:
  - The cycle after the accept: CS=0, DC=IN_DC, MOSI=IN_DATA[MSB], LCD_CLK=0. The word and IN_LAST are latched; the state moves to SHIFT.
- State SHIFT:
  - Each bit: LCD_CLK low for SPI_DIV cycles, then high for SPI_DIV cycles.
  - MOSI changes only at the start of a low phase, so it is stable across the rising edge.
  - Word time is DATA_WIDTH*2*SPI_DIV cycles.
  - DC is stable for the whole word.
- After the final high phase:
  - LCD_CLK=0.
  - If last=1: go to CS_HOLD. CS_HOLD lasts SPI_DIV cycles with CS low, then CS=1 and the state moves to IDLE.
  - If last=0: go straight to IDLE with CS still low.
  - An accept in that IDLE cycle starts the next word with no gap beyond the 1-cycle load.
- Accepted delay token:
  - Forces CS=1 on entry.
  - State DELAY counts IN_DATA[15:0]*CLOCK_SPEED_MHZ*1000 cycles, using a 32-bit counter, then returns to IDLE.
  - Count 0 means DELAY lasts exactly 1 cycle.
  - DC and MOSI hold their previous values.
- IN_VALID/IN_DATA are sampled only on accept; changes while busy are ignored. Upstream may hold IN_VALID high indefinitely.
- An asynchronous reset mid-word aborts immediately: all outputs return to their reset values and the full reset sequence reruns.
- BUSY = !(state==IDLE).

Test Plan:
- Use CLOCK_SPEED_MHZ=1, SPI_DIV=2, DATA_WIDTH=8, RESET_LOW_US=2, RESET_WAIT_MS=1. Assert SYSTEM_RST, then release it.
  -> LCD_RESET low exactly 2 cycles, then high. INIT_DONE rises 1000 cycles later. IN_READY=0 throughout; CS=1 throughout.
- After init, send one word IN_DATA=0xA5, IN_DC=0, IN_LAST=1.
  -> CS low for 32+2 cycles. 8 LCD_CLK rising edges sample MOSI=1,0,1,0,0,1,0,1. DC=0. CS returns high. IN_READY=1 afterwards.
- Back-to-back words 0x2A (DC=0, LAST=0) then 0x00 (DC=1, LAST=1) with IN_VALID held high.
  -> CS stays low across both words. DC switches 0->1 only at the second load. 16 rising edges total.
- Delay token IN_DELAY=1, IN_DATA=3.
  -> BUSY for 3000 cycles. LCD_CLK static 0. CS=1. Next word accepted at cycle 3001.
- HW_RESET_REQ and IN_VALID both high in IDLE.
  -> Word not accepted. INIT_DONE=0. LCD_RESET low 2 cycles. Word accepted only after the new INIT_DONE.
- Assert SYSTEM_RST at bit 4 of a word.
  -> CS=1, LCD_CLK=0, LCD_RESET=0 immediately (asynchronously). The sequence restarts; no partial word completes.
